decoder_scan_seq: RTL
=====================

// Module: decoder_scan_seq
// PURPOSE
//  Upstream sequencer for the 4-to-16 decoder: generates the A[3:0] address and E enable that step the
//  decoder across its 16 outputs (LED/keypad row scan). Each unmasked channel is held for a programmable
//  dwell time, with one blanking cycle (E=0) between channels. Supports one-shot and continuous modes.
//  Outputs are registered and connect directly to the decoder's A and E inputs.
// PARAMETERS
//  ADDR_W   4   address width; channel count = 2**ADDR_W (16)
//  DWELL_W  8   width of dwell-time input
// PORTS
//  clk        in   1         single clock, rising edge
//  rst        in   1         synchronous, active-high reset
//  start      in   1         level, sampled in IDLE only; begins a scan
//  stop       in   1         aborts the scan; priority over start
//  mode       in   1         0 = one-shot (single pass), 1 = continuous (wrap)
//  dwell      in   DWELL_W   cycles E stays high per channel; 0 treated as 1
//  ch_mask    in   16        1 = channel visited, 0 = skipped
//  addr       out  ADDR_W    to decoder A
//  en         out  1         to decoder E
//  busy       out  1         high in ACTIVE/BLANK
//  done       out  1         1-cycle pulse at end of a one-shot pass (or empty mask)
//  wrap       out  1         1-cycle pulse when continuous mode wraps to the lowest channel
// BEHAVIOUR
//  - Reset: state=IDLE, addr=0, en=0, busy=0, done=0, wrap=0, dwell counter=0.
//  - mode, dwell and ch_mask are latched on the accepted start; later changes have no effect until the next start.
//  - States: IDLE -> ACTIVE <-> BLANK -> DONE -> IDLE.
//  - IDLE: en=0; addr holds its last value. On edge with start=1, stop=0:
//      mask==0 -> DONE (en never rises); else addr=lowest set bit, en=1, ACTIVE.
//      Start to en latency = 1 edge.
//  - ACTIVE: en=1 for exactly max(dwell,1) cycles (counter 1..dwell_eff). On final count:
//      en=0 and go to BLANK.
//  - BLANK: exactly 1 cycle with en=0; addr updates at the same edge it enters BLANK
//      (address never changes while en=1). Next channel = next set mask bit above addr.
//      If none exists: one-shot -> DONE; continuous -> wrap to lowest set bit, assert wrap
//      (single-channel mask wraps to itself), then ACTIVE.
//  - DONE: done=1 for 1 cycle, en=0, busy=0, then IDLE.
//  - stop=1 in ACTIVE/BLANK: next edge state=IDLE, en=0, busy=0, no done pulse; addr holds.
//  - start while busy is ignored. start and stop both high in IDLE: stay IDLE.
//  - rst mid-scan: all outputs return to reset values at that edge.
//  - Counter is DWELL_W bits wide and compares against the latched dwell_eff; no overflow path.
//  - Invariant (checked by assertion): en=1 implies ch_mask_latched[addr]=1.
// STRUCTURE
//  - Shared package/include decoder_scan_defs: state encodings S_IDLE/S_ACTIVE/S_BLANK/S_DONE
//    (2-bit) and NUM_CH = 16.
//  - Sub-module scan_next_sel (combinational): inputs mask[15:0] and cur[3:0]; outputs nxt[3:0],
//    found_above and any_set. Used for both the first-channel search (cur forced to lowest)
//    and the advance search.
//  - Top level: FSM, dwell counter, latch registers and output registers.
// TESTING
//  1. rst=1 for 2 clocks -> addr=0, en=0, busy=0, done=0, wrap=0.
//  2. mask=16'hFFFF, dwell=2, mode=0, start pulse -> addr steps 0..15; en high 2 cycles and low
//     1 cycle per channel (48 cycles); done pulses once after channel 15; then IDLE.
//  3. mask=16'h8421, dwell=0, mode=1 -> addr 0,5,10,15,0,...; en high 1 cycle per channel;
//     wrap pulses on each 15->0 transition; done never asserts.
//  4. mask=16'h0000, start -> done pulses 1 edge after start; en stays 0; busy stays 0.
//  5. stop asserted during the 3rd cycle of dwell=5 on addr=3 -> next edge en=0, busy=0,
//     addr=3, no done; a later start restarts from the lowest set channel.
//  6. rst asserted mid-ACTIVE on addr=7 -> next edge all outputs at reset values; start while
//     busy and start+stop in IDLE both ignored.
// Decoder-level check (all tests): decoder Y is one-hot equal to (1<<addr) when en=1, and 0 otherwise.

Source files
------------

// File: rtl/decoder_scan_seq_pkg.sv
// Shared definitions for the decoder scan sequencer: FSM encodings and channel count.
package decoder_scan_defs;

   localparam int NUM_CH = 16;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_BLANK  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/decoder_scan_seq_if.sv
// Control and decoder-facing signals of the scan sequencer, bundled with master/slave views.
interface decoder_scan_if
   import decoder_scan_defs::*;
#(
   parameter int ADDR_W  = 4,
   parameter int DWELL_W = 8
);
   localparam int NCH = 2 ** ADDR_W;

   // start is a level request: it is taken on any edge where the sequencer is in IDLE
   // and stop is low; while busy it is ignored, so no ready/ack is needed.
   logic               start;
   logic               stop;
   logic               mode;
   logic [DWELL_W-1:0] dwell;
   logic [NCH-1:0]     ch_mask;
   logic [ADDR_W-1:0]  addr;
   logic               en;
   logic               busy;
   logic               done;
   logic               wrap;
   state_t             dbg_state;

   modport master (
      output start, stop, mode, dwell, ch_mask,
      input  addr, en, busy, done, wrap, dbg_state
   );

   modport slave (
      input  start, stop, mode, dwell, ch_mask,
      output addr, en, busy, done, wrap, dbg_state
   );

endinterface

// File: rtl/decoder_scan_seq_scan_next_sel.sv
// Picks the next set mask bit strictly above cur; when none exists nxt is the lowest set bit.
module scan_next_sel #(
   parameter int ADDR_W = 4
) (
   input  logic [2**ADDR_W-1:0] mask,
   input  logic [ADDR_W-1:0]    cur,
   output logic [ADDR_W-1:0]    nxt,
   output logic                 found_above,
   output logic                 any_set
);
   localparam int NCH = 2 ** ADDR_W;

   logic [ADDR_W-1:0] lowest;
   logic [ADDR_W-1:0] above;

   // Descending scans so the last hit is the lowest qualifying index.
   always_comb begin
      lowest      = '0;
      above       = '0;
      found_above = 1'b0;
      any_set     = |mask;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (mask[i]) begin
            lowest = ADDR_W'(i);
            if (i > int'(cur)) begin
               above       = ADDR_W'(i);
               found_above = 1'b1;
            end
         end
      end
      nxt = found_above ? above : lowest;
   end

endmodule

// File: rtl/decoder_scan_seq.sv
// Address/enable sequencer stepping a 4-to-16 decoder over masked channels with dwell and blanking.
module decoder_scan_seq
   import decoder_scan_defs::*;
#(
   parameter int ADDR_W  = 4,
   parameter int DWELL_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   decoder_scan_if.slave  bus
);
   localparam int NCH = 2 ** ADDR_W;

   state_t             state;
   logic [NCH-1:0]     mask_q;
   logic               mode_q;
   logic [DWELL_W-1:0] dwell_eff_q;
   logic [DWELL_W-1:0] cnt;
   logic               last_q;
   logic [ADDR_W-1:0]  addr_q;
   logic               en_q;
   logic               busy_q;
   logic               done_q;
   logic               wrap_q;

   logic [NCH-1:0]     sel_mask;
   logic [ADDR_W-1:0]  sel_cur;
   logic [ADDR_W-1:0]  nxt;
   logic               found_above;
   logic               any_set;
   logic [DWELL_W-1:0] dwell_eff_in;

   // In IDLE, searching from the top index makes nxt fall back to the lowest set bit.
   assign sel_mask     = (state == S_IDLE) ? bus.ch_mask : mask_q;
   assign sel_cur      = (state == S_IDLE) ? '1 : addr_q;
   assign dwell_eff_in = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

   scan_next_sel #(.ADDR_W(ADDR_W)) u_next_sel (
      .mask        (sel_mask),
      .cur         (sel_cur),
      .nxt         (nxt),
      .found_above (found_above),
      .any_set     (any_set)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         mask_q      <= '0;
         mode_q      <= 1'b0;
         dwell_eff_q <= DWELL_W'(1);
         cnt         <= '0;
         last_q      <= 1'b0;
         addr_q      <= '0;
         en_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         wrap_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start && !bus.stop) begin
                  mask_q      <= bus.ch_mask;
                  mode_q      <= bus.mode;
                  dwell_eff_q <= dwell_eff_in;
                  last_q      <= 1'b0;
                  if (!any_set) begin
                     state  <= S_DONE;
                     done_q <= 1'b1;
                  end else begin
                     state  <= S_ACTIVE;
                     addr_q <= nxt;
                     en_q   <= 1'b1;
                     busy_q <= 1'b1;
                     cnt    <= DWELL_W'(1);
                  end
               end
            end
            S_ACTIVE: begin
               if (bus.stop) begin
                  state  <= S_IDLE;
                  en_q   <= 1'b0;
                  busy_q <= 1'b0;
                  cnt    <= '0;
               end else if (cnt == dwell_eff_q) begin
                  // Address moves together with en falling, never while en is high.
                  state <= S_BLANK;
                  en_q  <= 1'b0;
                  cnt   <= '0;
                  if (found_above) begin
                     addr_q <= nxt;
                  end else if (mode_q) begin
                     addr_q <= nxt;
                     wrap_q <= 1'b1;
                  end else begin
                     last_q <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + DWELL_W'(1);
               end
            end
            S_BLANK: begin
               if (bus.stop) begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end else if (last_q) begin
                  state  <= S_DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  state <= S_ACTIVE;
                  en_q  <= 1'b1;
                  cnt   <= DWELL_W'(1);
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.addr      = addr_q;
   assign bus.en        = en_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.wrap      = wrap_q;
   assign bus.dbg_state = state;

   a_en_on_masked: assert property (@(posedge clk) disable iff (rst) en_q |-> mask_q[addr_q]);

endmodule
